// File: rtl/stack_port_pkg.sv
// stack_port_pkg: shared encodings for the LIFO port controller.
// Op codes, FSM states, error bit positions and data width.
package stack_port_pkg;

    localparam int DATA_W = 16;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;

    typedef enum logic [1:0] {
        OP_PUSH    = 2'b00,
        OP_POP     = 2'b01,
        OP_REPLACE = 2'b10,
        OP_RSVD    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/stack_port_ctrl.sv
// stack_port_ctrl: one-at-a-time request sequencer for the 16-bit LIFO.
// Optional occupancy counter + consistency check: STACK_PORT_CTRL_LEVEL_EN.
module stack_port_ctrl
    import stack_port_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int LOG2_DEPTHP1 = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [DATA_W-1:0]       req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [1:0]              rsp_err,
    output logic                    lifo_push,
    output logic                    lifo_pop,
    output logic [DATA_W-1:0]       lifo_data,
    input  logic [DATA_W-1:0]       lifo_q,
    input  logic                    lifo_full,
    input  logic                    lifo_empty,
    output logic [LOG2_DEPTHP1-1:0] level
);

    state_e            state;
    state_e            state_nxt;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [1:0]        rsp_err_q;
    logic [1:0]        err_nxt;
    logic              push;
    logic              pop;
    logic              level_bad;

`ifdef STACK_PORT_CTRL_LEVEL_EN
    localparam logic [LOG2_DEPTHP1-1:0] LVL_MAX = LOG2_DEPTHP1'(DEPTH);

    logic [LOG2_DEPTHP1-1:0] level_q;

    // Occupancy tracks issued strobes; REPLACE (both strobes) is neutral.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= '0;
        end else if (lifo_push && !lifo_pop && level_q != LVL_MAX) begin
            level_q <= level_q + 1'b1;
        end else if (lifo_pop && !lifo_push && level_q != '0) begin
            level_q <= level_q - 1'b1;
        end
    end

    assign level     = level_q;
    assign level_bad = lifo_empty != (level_q == '0);
`else
    localparam int unused_depth = DEPTH;

    assign level     = '0;
    assign level_bad = 1'b0;
`endif

    // Next state, strobes and error flags decided from the latched request.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        pop       = 1'b0;
        err_nxt   = '0;
        unique case (state)
            S_IDLE: begin
                if (req_valid) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (op_q == OP_RSVD || level_bad) begin
                    err_nxt[ERR_UNF] = 1'b1;
                    state_nxt        = S_RESP;
                end else if (op_q == OP_PUSH && lifo_full) begin
                    err_nxt[ERR_OVF] = 1'b1;
                    state_nxt        = S_RESP;
                end else if (op_q != OP_PUSH && lifo_empty) begin
                    err_nxt[ERR_UNF] = 1'b1;
                    state_nxt        = S_RESP;
                end else begin
                    push      = op_q != OP_POP;
                    pop       = op_q != OP_PUSH;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Latch the accepted request; data stays on lifo_data until the next one.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q   <= '0;
            data_q <= '0;
        end else if (state == S_IDLE && req_valid) begin
            op_q   <= req_op;
            data_q <= req_data;
        end
    end

    // Response registers: errors load in ISSUE, LIFO output loads in WAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_data_q <= '0;
            rsp_err_q  <= '0;
        end else if (state == S_ISSUE && err_nxt != '0) begin
            rsp_data_q <= '0;
            rsp_err_q  <= err_nxt;
        end else if (state == S_WAIT) begin
            rsp_data_q <= lifo_q;
            rsp_err_q  <= '0;
        end
    end

    assign req_ready = state == S_IDLE;
    assign rsp_valid = state == S_RESP;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign lifo_data = data_q;
    assign lifo_push = push & ~reset;
    assign lifo_pop  = pop & ~reset;

endmodule

// File: tb/tb_stack_port_ctrl.sv
// tb_stack_port_ctrl: table vectors plus corner sequences against a LIFO model.
// Expected responses are queued at issue and popped when the DUT responds.
module tb_stack_port_ctrl;
    import stack_port_pkg::*;

`ifdef STACK_PORT_CTRL_LEVEL_EN
    localparam int LVL_ON = 1;
`else
    localparam int LVL_ON = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [15:0] req_data = 16'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_err;
    logic        lifo_push;
    logic        lifo_pop;
    logic [15:0] lifo_data;
    logic [15:0] lifo_q = 16'h0;
    logic        lifo_full = 1'b0;
    logic        lifo_empty = 1'b1;
    logic [4:0]  level;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  e;
    } rsp_t;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] d;
        logic [15:0] ed;
        logic [1:0]  ee;
        int          ep;
        int          epp;
    } vec_t;

    rsp_t exp_q[$];
    vec_t vt[9];

    logic [15:0] mem[16];
    int          cnt = 0;

    stack_port_ctrl #(.DEPTH(16), .LOG2_DEPTHP1(5)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .lifo_push(lifo_push), .lifo_pop(lifo_pop),
        .lifo_data(lifo_data), .lifo_q(lifo_q),
        .lifo_full(lifo_full), .lifo_empty(lifo_empty),
        .level(level)
    );

    always #5 clock = ~clock;

    // Behavioural 16-deep LIFO with registered output and flags.
    always @(posedge clock) begin
        if (lifo_push && lifo_pop) begin
            if (cnt > 0) begin
                mem[cnt-1] <= lifo_data;
                lifo_q     <= lifo_data;
            end
        end else if (lifo_push) begin
            if (cnt < 16) begin
                mem[cnt]   <= lifo_data;
                lifo_q     <= lifo_data;
                cnt        <= cnt + 1;
                lifo_full  <= (cnt + 1) == 16;
                lifo_empty <= 1'b0;
            end
        end else if (lifo_pop) begin
            if (cnt > 0) begin
                lifo_q     <= mem[cnt-1];
                cnt        <= cnt - 1;
                lifo_empty <= cnt == 1;
                lifo_full  <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [15:0] d,
                         input logic [15:0] ed, input logic [1:0] ee,
                         input int ep, input int epp, input int hold);
        int   lat;
        int   np;
        int   npp;
        int   nb;
        logic seen;
        rsp_t e;
        logic [15:0] first;
        exp_q.push_back('{ed, ee});
        @(negedge clock);
        chk("req_ready_idle", req_ready, 1);
        rsp_ready = (hold == 0);
        req_op    = op;
        req_data  = d;
        req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        lat = 0; np = 0; npp = 0; nb = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clock);
            lat++;
            np  += int'(lifo_push);
            npp += int'(lifo_pop);
            nb  += int'(lifo_push && lifo_pop);
            if (rsp_valid) seen = 1'b1;
            else chk("req_ready_busy", req_ready, 0);
        end
        if (!seen) begin
            chk("rsp_valid_timeout", rsp_valid, 1);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data, e.d);
            chk("rsp_err", rsp_err, e.e);
            chk("latency", lat, (ee != 2'b00) ? 2 : 3);
            chk("push_cycles", np, ep);
            chk("pop_cycles", npp, epp);
            chk("both_cycles", nb, (ep == 1 && epp == 1) ? 1 : 0);
            first = rsp_data;
            for (int i = 0; i < hold; i++) begin
                @(negedge clock);
                chk("hold_valid", rsp_valid, 1);
                chk("hold_data", rsp_data, first);
                chk("hold_ready", req_ready, 0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        vt[0] = '{2'b01, 16'h0000, 16'h0000, 2'b10, 0, 0};
        vt[1] = '{2'b10, 16'h1111, 16'h0000, 2'b10, 0, 0};
        vt[2] = '{2'b11, 16'h2222, 16'h0000, 2'b10, 0, 0};
        vt[3] = '{2'b00, 16'h1234, 16'h1234, 2'b00, 1, 0};
        vt[4] = '{2'b01, 16'h0000, 16'h1234, 2'b00, 0, 1};
        vt[5] = '{2'b00, 16'h0005, 16'h0005, 2'b00, 1, 0};
        vt[6] = '{2'b10, 16'hAAAA, 16'hAAAA, 2'b00, 1, 1};
        vt[7] = '{2'b01, 16'h0000, 16'hAAAA, 2'b00, 0, 1};
        vt[8] = '{2'b11, 16'h3333, 16'h0000, 2'b10, 0, 0};

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_push", lifo_push, 0);
        chk("rst_pop", lifo_pop, 0);
        chk("rst_level", level, 0);

        for (int i = 0; i < 9; i++)
            do_op(vt[i].op, vt[i].d, vt[i].ed, vt[i].ee,
                  vt[i].ep, vt[i].epp, 0);

        do_op(2'b00, 16'h0001, 16'h0001, 2'b00, 1, 0, 0);
        do_op(2'b00, 16'h0002, 16'h0002, 2'b00, 1, 0, 0);
        do_op(2'b00, 16'h0003, 16'h0003, 2'b00, 1, 0, 0);
        do_op(2'b01, 16'h0000, 16'h0003, 2'b00, 0, 1, 0);
        chk("level_after_pop", level, LVL_ON * 2);
        do_op(2'b10, 16'h0007, 16'h0007, 2'b00, 1, 1, 0);
        chk("level_after_repl", level, LVL_ON * 2);
        do_op(2'b01, 16'h0000, 16'h0007, 2'b00, 0, 1, 0);
        do_op(2'b01, 16'h0000, 16'h0001, 2'b00, 0, 1, 0);

        for (int i = 0; i < 16; i++)
            do_op(2'b00, 16'(i), 16'(i), 2'b00, 1, 0, 0);
        chk("level_full", level, LVL_ON * 16);
        do_op(2'b00, 16'hBEEF, 16'h0000, 2'b01, 0, 0, 0);
        chk("level_ovf", level, LVL_ON * 16);
        for (int i = 15; i >= 0; i--)
            do_op(2'b01, 16'h0000, 16'(i), 2'b00, 0, 1, 0);
        chk("level_drained", level, 0);
        do_op(2'b01, 16'h0000, 16'h0000, 2'b10, 0, 0, 0);

        do_op(2'b00, 16'h5A5A, 16'h5A5A, 2'b00, 1, 0, 5);

        @(negedge clock);
        req_op = 2'b00; req_data = 16'h0C0C; req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        chk("wait_seq_push", lifo_push, 1);
        @(negedge clock);
        chk("wait_seq_state", {rsp_valid, req_ready}, 2'b00);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("wrst_req_ready", req_ready, 1);
        chk("wrst_rsp_valid", rsp_valid, 0);
        chk("wrst_rsp_data", rsp_data, 0);
        chk("wrst_rsp_err", rsp_err, 0);
        chk("wrst_strobes", {lifo_push, lifo_pop}, 2'b00);
        chk("wrst_level", level, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_valid", rsp_valid, 0);

        if (LVL_ON != 0)
            do_op(2'b01, 16'h0000, 16'h0000, 2'b10, 0, 0, 0);
        else
            do_op(2'b01, 16'h0000, 16'h0C0C, 2'b00, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
